// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time loader for the single-cycle RV32 core. A framed program image
// arrives as a byte stream, is assembled into little-endian 32-bit words and
// written into the core's instruction memory. The core is held in reset until
// the whole image has been written and its checksum matches.
//
// Frame: 0xA5 | N[7:0] | N[15:8] | 4*N payload bytes | XOR of payload bytes
//
// Ports:
//   clock       single clock
//   reset       synchronous, active-high
//   in_valid    byte-stream data valid
//   in_data     byte-stream data
//   in_ready    block can take a byte this cycle (combinational from state)
//   restart     one-cycle pulse: drop everything and wait for a new frame
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   word address of the write
//   imem_wdata  word written
//   cpu_reset   reset to the core; low only once the image is loaded
//   done        image loaded and checksum OK
//   error       bad length or bad checksum
//   word_count  words written in the current frame
// -----------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WIDTH-1:0]  imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [2:0] S_SYNC   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CHK    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam logic [15:0] MAX_LEN   = 16'(DEPTH);

   logic [2:0]  state;
   logic [7:0]  len_lo;      // low length byte, held until the high byte arrives
   logic [15:0] len;         // frame length in words
   logic [1:0]  byte_idx;    // lane of the next payload byte within its word
   logic [23:0] asm_lo;      // lanes 0..2 of the word being assembled
   logic [7:0]  chk;         // running XOR of payload bytes

   logic        xfer;
   logic [15:0] rx_len;
   logic        last_word;

   // Only DONE refuses bytes; ERROR keeps accepting so it can resynchronise.
   assign in_ready  = (state != S_DONE);
   assign xfer      = in_valid && in_ready;
   assign rx_len    = {in_data, len_lo};
   // word_count is current by the time the next word's 4th byte arrives (the
   // previous write happened at least three cycles earlier), so it indexes
   // the word that is completing now.
   assign last_word = (16'(word_count) + 16'd1) == len;

   // NOTE: every register here is updated with non-blocking assignments so
   // all of them see the pre-edge values of each other within one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_SYNC;
         len_lo     <= '0;
         len        <= '0;
         byte_idx   <= '0;
         asm_lo     <= '0;
         chk        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         // NOTE: the write strobe defaults low every cycle, which is what
         // makes it a single-cycle pulse and drops it on restart.
         imem_we <= 1'b0;

         if (restart) begin
            // A partial word is simply abandoned; nothing is written for it.
            state      <= S_SYNC;
            byte_idx   <= '0;
            chk        <= '0;
            word_count <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
         end else if (xfer) begin
            case (state)
               S_SYNC: begin
                  if (in_data == SYNC_BYTE) state <= S_LEN_LO;
               end

               S_LEN_LO: begin
                  len_lo <= in_data;
                  state  <= S_LEN_HI;
               end

               S_LEN_HI: begin
                  len <= rx_len;
                  if (rx_len == 16'd0 || rx_len > MAX_LEN) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else begin
                     state      <= S_DATA;
                     word_count <= '0;
                     chk        <= '0;
                     byte_idx   <= '0;
                  end
               end

               S_DATA: begin
                  chk      <= chk ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_lo[7:0]   <= in_data;
                     2'd1: asm_lo[15:8]  <= in_data;
                     2'd2: asm_lo[23:16] <= in_data;
                     default: begin
                        // Lane 3 goes straight into the write data, so the
                        // word is written the cycle after its last byte.
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= {in_data, asm_lo};
                        word_count <= word_count + 1'b1;
                        if (last_word) state <= S_CHK;
                     end
                  endcase
               end

               S_CHK: begin
                  // Words already written stay written on a mismatch.
                  if (in_data == chk) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end

               S_ERROR: begin
                  if (in_data == SYNC_BYTE) begin
                     state <= S_LEN_LO;
                     error <= 1'b0;
                  end
               end

               default: ;  // DONE never sees a transfer; it waits for restart
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader. The bench plays the instruction
// memory (it captures every write) and builds frames from word arrays; the
// expected checksum, addresses, data and status are derived from the frame
// contents with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              restart = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WIDTH-1:0]  imem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   imem_boot_loader #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .restart   (restart),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error),
      .word_count(word_count)
   );

   always #5 clock = ~clock;

   // Emulated instruction memory plus write bookkeeping.
   logic [31:0] tb_mem [0:DEPTH-1];
   int          we_count  = 0;
   int          last_addr = -1;

   always @(posedge clock) begin
      if (imem_we) begin
         tb_mem[imem_addr] <= imem_wdata;
         we_count          <= we_count + 1;
         last_addr         <= int'(imem_addr);
      end
   end

   logic [31:0] payload [0:DEPTH-1];
   int n_checks = 0;
   int n_errors = 0;

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------- helpers
   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b1;
      in_valid = 1'b0;
      restart  = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulse_restart();
      @(negedge clock);
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge one cycle after the transfer.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      n_checks++;
      if (!in_ready) begin
         $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
         n_errors++;
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic idle_gaps(input int pct);
      int g;
      g = 0;
      while (pct > 0 && g < 6 && $urandom_range(99) < pct) begin
         @(negedge clock);
         g++;
      end
   endtask

   // Sends a full frame of n words from payload[]; the checksum byte is the
   // XOR of the payload bytes XOR'ed with mask (mask != 0 makes it wrong).
   task automatic send_frame(input int n, input logic [7:0] mask, input int pct);
      logic [7:0]  x;
      logic [7:0]  b;
      logic [15:0] len16;
      int          base_we;
      x       = 8'h00;
      len16   = 16'(n);
      base_we = we_count;

      send_byte(8'hA5);
      n_checks++;
      if (error !== 1'b0) begin
         $display("FAIL sync_clears_error: error=%b required 0", error);
         n_errors++;
      end
      idle_gaps(pct);
      send_byte(len16[7:0]);
      idle_gaps(pct);
      send_byte(len16[15:8]);

      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = payload[k][8*j +: 8];
            x = x ^ b;
            idle_gaps(pct);
            send_byte(b);
            if (j == 3) begin
               n_checks++;
               if (imem_we !== 1'b1 || int'(imem_addr) != k || imem_wdata !== payload[k]) begin
                  $display("FAIL word_write[%0d]: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                           k, imem_we, imem_addr, imem_wdata, k, payload[k]);
                  n_errors++;
               end
            end
         end
      end

      idle_gaps(pct);
      n_checks++;
      if (done !== 1'b0 || cpu_reset !== 1'b1) begin
         $display("FAIL pre_chk_status: done=%b cpu_reset=%b required 0/1", done, cpu_reset);
         n_errors++;
      end
      send_byte(x ^ mask);

      // Status is registered on the checksum edge: visible right now.
      n_checks++;
      if (mask == 8'h00) begin
         if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL frame_ok_status: done=%b cpu_reset=%b error=%b in_ready=%b required 1/0/0/0",
                     done, cpu_reset, error, in_ready);
            n_errors++;
         end
      end else begin
         if (done !== 1'b0 || cpu_reset !== 1'b1 || error !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL frame_bad_chk_status: done=%b cpu_reset=%b error=%b in_ready=%b required 0/1/1/1",
                     done, cpu_reset, error, in_ready);
            n_errors++;
         end
      end

      n_checks++;
      if (int'(word_count) != n || (we_count - base_we) != n) begin
         $display("FAIL frame_word_count: word_count=%0d writes=%0d required %0d",
                  word_count, we_count - base_we, n);
         n_errors++;
      end

      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (tb_mem[k] !== payload[k]) begin
            $display("FAIL imem_contents[%0d]: got %h required %h", k, tb_mem[k], payload[k]);
            n_errors++;
         end
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      do_reset();
      n_checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || imem_we !== 1'b0 ||
          imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0 || in_ready !== 1'b1) begin
         $display("FAIL reset_values: cpu_reset=%b done=%b error=%b we=%b addr=%0d wdata=%h wc=%0d rdy=%b",
                  cpu_reset, done, error, imem_we, imem_addr, imem_wdata, word_count, in_ready);
         n_errors++;
      end
   endtask

   task automatic test_basic();
      do_reset();
      payload[0] = 32'h00100513;
      payload[1] = 32'h00200593;
      send_frame(2, 8'h00, 0);
   endtask

   task automatic test_bad_checksum();
      do_reset();
      payload[0] = 32'h00100513;
      payload[1] = 32'h00200593;
      // Correct checksum is 0xB0; this mask sends 0x24 instead.
      send_frame(2, 8'h94, 0);
      // Resynchronise straight out of ERROR with a one-word frame.
      payload[0] = 32'hDEADBEEF;
      send_frame(1, 8'h00, 0);
   endtask

   task automatic test_bad_length();
      int          base_we;
      logic [7:0]  b;
      do_reset();
      base_we = we_count;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      n_checks++;
      if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b1) begin
         $display("FAIL len_too_big: error=%b cpu_reset=%b in_ready=%b required 1/1/1",
                  error, cpu_reset, in_ready);
         n_errors++;
      end
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h00;
         send_byte(b);
      end
      n_checks++;
      if (error !== 1'b1) begin
         $display("FAIL error_holds: error=%b required 1", error);
         n_errors++;
      end
      send_byte(8'hA5);
      n_checks++;
      if (error !== 1'b0) begin
         $display("FAIL error_resync: error=%b required 0", error);
         n_errors++;
      end
      send_byte(8'h00);
      send_byte(8'h00);
      n_checks++;
      if (error !== 1'b1 || done !== 1'b0) begin
         $display("FAIL len_zero: error=%b done=%b required 1/0", error, done);
         n_errors++;
      end
      n_checks++;
      if (we_count != base_we) begin
         $display("FAIL bad_len_no_write: writes=%0d required 0", we_count - base_we);
         n_errors++;
      end
   endtask

   task automatic test_garbage_and_done();
      logic [7:0] garbage [3];
      int         base_we;
      garbage[0] = 8'h00;
      garbage[1] = 8'hFF;
      garbage[2] = 8'h5A;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_ready !== 1'b1) begin
            $display("FAIL garbage_ready[%0d]: in_ready=%b required 1", i, in_ready);
            n_errors++;
         end
         send_byte(garbage[i]);
      end
      payload[0] = $urandom;
      payload[1] = $urandom;
      send_frame(2, 8'h00, 0);

      base_we = we_count;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = (i == 0) ? 8'hA5 : 8'($urandom);
      end
      @(negedge clock);
      in_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b0 || in_ready !== 1'b0 ||
          we_count != base_we || word_count !== 10'd2) begin
         $display("FAIL done_ignores_input: done=%b cpu_reset=%b rdy=%b writes=%0d wc=%0d required 1/0/0/0/2",
                  done, cpu_reset, in_ready, we_count - base_we, word_count);
         n_errors++;
      end
   endtask

   task automatic test_reset_midframe();
      int base_we;
      do_reset();
      for (int k = 0; k < 3; k++) payload[k] = $urandom;
      base_we = we_count;
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h00);
      for (int j = 0; j < 6; j++) send_byte(payload[j / 4][8*(j % 4) +: 8]);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || imem_we !== 1'b0 ||
          word_count !== '0 || in_ready !== 1'b1) begin
         $display("FAIL midframe_reset_state: cpu_reset=%b done=%b error=%b we=%b wc=%0d rdy=%b",
                  cpu_reset, done, error, imem_we, word_count, in_ready);
         n_errors++;
      end
      n_checks++;
      if (we_count - base_we != 1) begin
         $display("FAIL midframe_partial_write: writes=%0d required 1", we_count - base_we);
         n_errors++;
      end
      for (int k = 0; k < 3; k++) payload[k] = $urandom;
      send_frame(3, 8'h00, 0);
   endtask

   task automatic test_restart_full_depth();
      // Leaves DONE from the previous test.
      pulse_restart();
      n_checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL restart_status: cpu_reset=%b done=%b error=%b rdy=%b required 1/0/0/1",
                  cpu_reset, done, error, in_ready);
         n_errors++;
      end
      for (int k = 0; k < DEPTH; k++) payload[k] = $urandom;
      send_frame(DEPTH, 8'h00, 50);
      n_checks++;
      if (last_addr != DEPTH - 1 || int'(word_count) != DEPTH) begin
         $display("FAIL full_depth_end: last_addr=%0d wc=%0d required %0d/%0d",
                  last_addr, word_count, DEPTH - 1, DEPTH);
         n_errors++;
      end
   endtask

   task automatic test_random_frames();
      int         n;
      logic [7:0] mask;
      for (int f = 0; f < 8; f++) begin
         if (done) pulse_restart();
         n    = int'($urandom_range(1, 12));
         mask = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         for (int k = 0; k < n; k++) payload[k] = $urandom;
         send_frame(n, mask, 30);
      end
   endtask

   task automatic test_restart_midword();
      int base_we;
      if (done) pulse_restart();
      for (int k = 0; k < 2; k++) payload[k] = $urandom;
      base_we = we_count;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      for (int j = 0; j < 3; j++) send_byte(payload[0][8*j +: 8]);
      pulse_restart();
      repeat (2) @(negedge clock);
      n_checks++;
      if (we_count != base_we || cpu_reset !== 1'b1 || error !== 1'b0) begin
         $display("FAIL restart_midword: writes=%0d cpu_reset=%b error=%b required 0/1/0",
                  we_count - base_we, cpu_reset, error);
         n_errors++;
      end
      send_frame(2, 8'h00, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_checksum();
      test_bad_length();
      test_garbage_and_done();
      test_reset_midframe();
      test_restart_full_depth();
      test_random_frames();
      test_restart_midword();
      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
